// File: rtl/avlstrm_stats_multi.sv
// avlstrm_stats_multi: passive multi-channel Avalon-ST statistics tap.
// Keeps saturating per-channel flit/pkt/rule(/err) counters, a shadow set
// loaded by snap_req, a clear by clr_req and a registered indexed read port.
// Optional feature: define STATS_PROTO_CHK_EN to build the sop/eop
// protocol-error counters; otherwise rd_sel=3 always reads 0.
module avlstrm_stats_multi #(
    parameter int unsigned    NCH       = 4,
    parameter int unsigned    DW        = 512,
    parameter int unsigned    RW        = 16,
    parameter int unsigned    CW        = 32,
    parameter logic [NCH-1:0] RULE_MASK = '0
) (
    input  logic                                      Clk,
    input  logic                                      Rst_n,
    input  logic [NCH-1:0]                            mon_valid,
    input  logic [NCH-1:0]                            mon_ready,
    input  logic [NCH-1:0]                            mon_sop,
    input  logic [NCH-1:0]                            mon_eop,
    input  logic [NCH*DW-1:0]                         mon_data,
    input  logic                                      snap_req,
    input  logic                                      clr_req,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]  rd_ch,
    input  logic [1:0]                                rd_sel,
    output logic [CW-1:0]                             rd_data,
    output logic                                      snap_done
);
    localparam int unsigned NS = DW / RW;
    localparam int unsigned SW = $clog2(NS + 1);

    logic [NCH-1:0] beat;
    logic [NS-1:0]  slot_flag [NCH];
    logic [NS-1:0]  slot_nz   [NCH];
    logic [CW-1:0]  flit_cnt  [NCH];
    logic [CW-1:0]  pkt_cnt   [NCH];
    logic [CW-1:0]  rule_cnt  [NCH];
    logic [CW-1:0]  sh_flit   [NCH];
    logic [CW-1:0]  sh_pkt    [NCH];
    logic [CW-1:0]  sh_rule   [NCH];
    logic [CW-1:0]  sh_err_rd;

    function automatic logic [SW-1:0] count_ones(input logic [NS-1:0] v);
        logic [SW-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < NS; i++) n = n + SW'(v[i]);
        return n;
    endfunction

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [SW-1:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + (CW+1)'(b);
        return s[CW] ? '1 : s[CW-1:0];
    endfunction

    assign beat = mon_valid & mon_ready;

    // Per-slot nonzero flags of every channel's current data beat
    always_comb begin
        for (int unsigned c = 0; c < NCH; c++) begin
            for (int unsigned s = 0; s < NS; s++) begin
                slot_flag[c][s] = |mon_data[c*DW + s*RW +: RW];
            end
        end
    end

    // Live counters, rule popcount pipeline and flit/pkt/rule shadow copies
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                flit_cnt[c] <= '0;
                pkt_cnt[c]  <= '0;
                rule_cnt[c] <= '0;
                slot_nz[c]  <= '0;
                sh_flit[c]  <= '0;
                sh_pkt[c]   <= '0;
                sh_rule[c]  <= '0;
            end
            snap_done <= 1'b0;
        end else begin
            snap_done <= snap_req;
            for (int unsigned c = 0; c < NCH; c++) begin
                if (snap_req) begin
                    sh_flit[c] <= flit_cnt[c];
                    sh_pkt[c]  <= pkt_cnt[c];
                    sh_rule[c] <= rule_cnt[c];
                end
                if (clr_req) begin
                    flit_cnt[c] <= '0;
                    pkt_cnt[c]  <= '0;
                    rule_cnt[c] <= '0;
                    slot_nz[c]  <= '0;
                end else begin
                    if (beat[c]) flit_cnt[c] <= sat_add(flit_cnt[c], SW'(1));
                    if (beat[c] && mon_eop[c]) pkt_cnt[c] <= sat_add(pkt_cnt[c], SW'(1));
                    // stage 1 holds zero flags when idle so stage 2 adds nothing
                    slot_nz[c]  <= (beat[c] && RULE_MASK[c]) ? slot_flag[c] : '0;
                    rule_cnt[c] <= sat_add(rule_cnt[c], count_ones(slot_nz[c]));
                end
            end
        end
    end

`ifdef STATS_PROTO_CHK_EN
    logic [NCH-1:0] in_pkt;
    logic [CW-1:0]  err_cnt [NCH];
    logic [CW-1:0]  sh_err  [NCH];

    // In-packet tracking and protocol-error counting (sop must equal !in_pkt)
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            in_pkt <= '0;
            for (int unsigned c = 0; c < NCH; c++) begin
                err_cnt[c] <= '0;
                sh_err[c]  <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < NCH; c++) begin
                if (beat[c]) begin
                    if (mon_eop[c])      in_pkt[c] <= 1'b0;
                    else if (mon_sop[c]) in_pkt[c] <= 1'b1;
                end
                if (snap_req) sh_err[c] <= err_cnt[c];
                if (clr_req) begin
                    err_cnt[c] <= '0;
                end else if (beat[c] && (mon_sop[c] == in_pkt[c])) begin
                    err_cnt[c] <= sat_add(err_cnt[c], SW'(1));
                end
            end
        end
    end

    assign sh_err_rd = sh_err[rd_ch];
`else
    logic unused_sop;
    assign unused_sop = ^mon_sop;
    assign sh_err_rd  = '0;
`endif

    // Registered read port over the shadow set
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            rd_data <= '0;
        end else if (32'(rd_ch) >= NCH) begin
            rd_data <= '0;
        end else begin
            case (rd_sel)
                2'd0:    rd_data <= sh_flit[rd_ch];
                2'd1:    rd_data <= sh_pkt[rd_ch];
                2'd2:    rd_data <= sh_rule[rd_ch];
                default: rd_data <= sh_err_rd;
            endcase
        end
    end

endmodule

// File: tb/tb_avlstrm_stats_multi.sv
// Self-checking bench for avlstrm_stats_multi: directed read tables, corner
// sequences and a randomized run against a counting reference model.
module tb_avlstrm_stats_multi;
    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 512;
    localparam int unsigned RW  = 16;
    localparam int unsigned CW  = 8;
    localparam int unsigned NS  = DW / RW;
    localparam logic [NCH-1:0] MASK = 4'b0010;
    localparam int MAXC = 255;
`ifdef STATS_PROTO_CHK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    logic              Clk = 1'b0;
    logic              Rst_n = 1'b0;
    logic [NCH-1:0]    mon_valid = '0;
    logic [NCH-1:0]    mon_ready = '0;
    logic [NCH-1:0]    mon_sop = '0;
    logic [NCH-1:0]    mon_eop = '0;
    logic [NCH*DW-1:0] mon_data = '0;
    logic              snap_req = 1'b0;
    logic              clr_req = 1'b0;
    logic [1:0]        rd_ch = '0;
    logic [1:0]        rd_sel = '0;
    logic [CW-1:0]     rd_data;
    logic              snap_done;

    avlstrm_stats_multi #(
        .NCH(NCH), .DW(DW), .RW(RW), .CW(CW), .RULE_MASK(MASK)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .mon_valid(mon_valid), .mon_ready(mon_ready),
        .mon_sop(mon_sop), .mon_eop(mon_eop), .mon_data(mon_data),
        .snap_req(snap_req), .clr_req(clr_req),
        .rd_ch(rd_ch), .rd_sel(rd_sel),
        .rd_data(rd_data), .snap_done(snap_done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int ch;
        int sel;
        int exp;
    } rd_vec_t;

    rd_vec_t vec [16];

    // reference model: unbounded totals, saturation applied when copied
    int live [NCH][4];
    int sh   [NCH][4];
    int pend [NCH];
    bit inp  [NCH];
    int n_chk = 0;
    int n_fail = 0;

    logic [DW-1:0] d5, dall, dz, dr;

    function automatic int sat(input int x);
        return (x > MAXC) ? MAXC : x;
    endfunction

    function automatic int nz_slots(input logic [DW-1:0] d);
        int n;
        n = 0;
        for (int s = 0; s < int'(NS); s++) if (d[s*RW +: RW] != '0) n++;
        return n;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // advance one cycle: update the model with the driven inputs, then compare
    task automatic tick();
        int exp_rd;
        int exp_done;
        bit b;
        exp_rd   = sh[rd_ch][rd_sel];
        exp_done = int'(snap_req);
        if (snap_req)
            for (int c = 0; c < int'(NCH); c++)
                for (int s = 0; s < 4; s++) sh[c][s] = sat(live[c][s]);
        for (int c = 0; c < int'(NCH); c++) begin
            b = mon_valid[c] && mon_ready[c];
            if (clr_req) begin
                for (int s = 0; s < 4; s++) live[c][s] = 0;
                pend[c] = 0;
            end else begin
                live[c][2] += pend[c];
                pend[c] = 0;
                if (b) begin
                    live[c][0]++;
                    if (mon_eop[c]) live[c][1]++;
                    if (MASK[c]) pend[c] = nz_slots(mon_data[c*DW +: DW]);
                    if (PCHK && (mon_sop[c] == inp[c])) live[c][3]++;
                end
            end
            if (b) begin
                if (mon_eop[c])      inp[c] = 1'b0;
                else if (mon_sop[c]) inp[c] = 1'b1;
            end
        end
        @(posedge Clk);
        #1;
        check("rd_data_model", int'(rd_data), exp_rd);
        check("snap_done", int'(snap_done), exp_done);
    endtask

    task automatic idle();
        mon_valid = '0; mon_ready = '0; mon_sop = '0; mon_eop = '0;
        snap_req = 1'b0; clr_req = 1'b0;
    endtask

    task automatic beat(input int c, input bit sop, input bit eop, input logic [DW-1:0] d);
        idle();
        mon_valid[c] = 1'b1; mon_ready[c] = 1'b1;
        mon_sop[c] = sop; mon_eop[c] = eop;
        mon_data[c*DW +: DW] = d;
        tick();
        idle();
    endtask

    task automatic pulse_snap();
        idle(); snap_req = 1'b1; tick(); snap_req = 1'b0;
    endtask

    task automatic pulse_clr();
        idle(); clr_req = 1'b1; tick(); clr_req = 1'b0;
    endtask

    task automatic rd(input int c, input int s, input int exp, input string name);
        rd_ch = 2'(c); rd_sel = 2'(s);
        tick();
        check(name, int'(rd_data), exp);
    endtask

    task automatic set_ch(input int c, input int f, input int p, input int r, input int e);
        vec[c*4+0] = '{c, 0, f};
        vec[c*4+1] = '{c, 1, p};
        vec[c*4+2] = '{c, 2, r};
        vec[c*4+3] = '{c, 3, e};
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < 16; i++) rd(vec[i].ch, vec[i].sel, vec[i].exp, name);
    endtask

    initial begin
        d5 = '0;
        d5[0*RW +: RW] = 16'h0001; d5[3*RW +: RW] = 16'h8000; d5[7*RW +: RW] = 16'h00f0;
        d5[20*RW +: RW] = 16'h1234; d5[31*RW +: RW] = 16'hffff;
        dall = {32{16'h0101}};
        dz = '0;

        // reset: outputs held at zero
        for (int i = 0; i < 3; i++) begin
            rd_ch = 2'(i); rd_sel = 2'(i);
            @(posedge Clk); #1;
            check("reset_rd_data", int'(rd_data), 0);
            check("reset_snap_done", int'(snap_done), 0);
        end
        Rst_n = 1'b1;
        for (int c = 0; c < 4; c++) set_ch(c, 0, 0, 0, 0);
        run_table("post_reset_read");

        // ch0 packets of 4/1/2 beats, ch1 rule beats of 5/32/0 slots
        beat(0, 1, 0, d5);  beat(0, 0, 0, dall); beat(0, 0, 0, dz); beat(0, 0, 1, d5);
        beat(0, 1, 1, dall);
        beat(0, 1, 0, dz);  beat(0, 0, 1, d5);
        beat(1, 1, 1, d5);  beat(1, 1, 1, dall); beat(1, 1, 1, dz);
        idle(); tick(); tick();
        pulse_snap();
        set_ch(0, 7, 3, 0, 0);
        set_ch(1, 3, 3, 37, 0);
        set_ch(2, 0, 0, 0, 0);
        set_ch(3, 0, 0, 0, 0);
        run_table("pkt_rule_snapshot");

        // saturation on ch2 with ready toggling
        pulse_clr();
        for (int i = 0; i < 300; i++) begin
            idle();
            mon_valid[2] = 1'b1; mon_ready[2] = (i % 2 == 0);
            mon_sop[2] = 1'b1; mon_eop[2] = 1'b1;
            mon_data[2*DW +: DW] = dall;
            tick();
        end
        pulse_snap();
        rd(2, 0, 150, "flit_150");
        rd(2, 1, 150, "pkt_150");
        for (int i = 0; i < 200; i++) begin
            idle();
            mon_valid[2] = 1'b1; mon_ready[2] = 1'b1;
            mon_sop[2] = 1'b1; mon_eop[2] = 1'b1;
            tick();
        end
        pulse_snap();
        rd(2, 0, 255, "flit_sat");
        rd(2, 1, 255, "pkt_sat");
        rd(2, 2, 0, "rule_unmasked");

        // snap and clear together while ch0/ch1 stream
        pulse_clr();
        for (int i = 0; i < 16; i++) begin
            idle();
            mon_valid[1:0] = 2'b11; mon_ready[1:0] = 2'b11;
            mon_sop[1:0] = 2'b11; mon_eop[1:0] = 2'b11;
            mon_data[0 +: DW] = d5; mon_data[DW +: DW] = d5;
            if (i == 10) begin snap_req = 1'b1; clr_req = 1'b1; end
            if (i == 11) begin rd_ch = 2'd0; rd_sel = 2'd0; end
            if (i == 12) begin rd_ch = 2'd1; rd_sel = 2'd2; end
            tick();
            if (i == 11) check("snapclr_flit_pre", int'(rd_data), 10);
            if (i == 12) check("snapclr_rule_pre", int'(rd_data), 45);
        end
        idle(); tick(); tick();
        pulse_snap();
        rd(0, 0, 5, "snapclr_flit_post");
        rd(1, 2, 25, "snapclr_rule_post");

        // protocol errors on ch3: sop, sop, eop, then a stray mid beat
        pulse_clr();
        beat(3, 1, 0, dz); beat(3, 1, 0, dz); beat(3, 0, 1, dz); beat(3, 0, 0, dz);
        idle(); tick();
        pulse_snap();
        rd(3, 0, 4, "proto_flit");
        rd(3, 1, 1, "proto_pkt");
        rd(3, 3, PCHK ? 2 : 0, "proto_err");

        // randomized traffic with snaps, clears and random reads
        pulse_clr();
        for (int i = 0; i < 3000; i++) begin
            idle();
            for (int c = 0; c < int'(NCH); c++) begin
                mon_valid[c] = 1'($urandom_range(0, 3) != 0);
                mon_ready[c] = 1'($urandom_range(0, 3) != 0);
                mon_sop[c]   = 1'($urandom_range(0, 2) == 0);
                mon_eop[c]   = 1'($urandom_range(0, 2) == 0);
                for (int s = 0; s < int'(NS); s++)
                    dr[s*RW +: RW] = ($urandom_range(0, 1) != 0) ? RW'($urandom_range(1, 65535)) : RW'(0);
                mon_data[c*DW +: DW] = dr;
            end
            snap_req = ($urandom_range(0, 15) == 0);
            clr_req  = ($urandom_range(0, 150) == 0);
            rd_ch  = 2'($urandom_range(0, 3));
            rd_sel = 2'($urandom_range(0, 3));
            tick();
        end
        idle(); tick(); tick();
        pulse_snap();
        for (int c = 0; c < int'(NCH); c++)
            for (int s = 0; s < 4; s++) rd(c, s, sat(live[c][s]), "random_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/avlstrm_stats_multi.md
# avlstrm_stats_multi

Parametrised, multi-channel statistics tap for Avalon-ST links in the Pigasus datapath. It generalises the per-module stats counters on port-group outputs into one block. It passively observes NCH streams and keeps saturating per-channel flit, packet, rule and protocol-error counters. A snapshot/clear mechanism and a registered indexed read port let software sample all channels coherently.

## Interface
Parameters:
- NCH, 4, number of observed stream channels
- DW, 512, data width per channel
- RW, 16, rule-ID slot width inside a usr data beat; DW must be a multiple of RW
- CW, 32, counter width
- RULE_MASK, NCH'b0, bit c set means channel c carries rule IDs and its rule counter is active

Ports:
- Clk  in  1  clock
- Rst_n  in  1  synchronous active-low reset, sampled on rising Clk
- mon_valid  in  NCH  per-channel valid
- mon_ready  in  NCH  per-channel ready
- mon_sop  in  NCH  per-channel start of packet
- mon_eop  in  NCH  per-channel end of packet
- mon_data  in  NCH*DW  channel c occupies bits [c*DW +: DW]
- snap_req  in  1  single-cycle pulse: copy live counters to shadow set
- clr_req  in  1  single-cycle pulse: zero live counters
- rd_ch  in  clog2(NCH) (min 1)  channel to read
- rd_sel  in  2  0=flit, 1=pkt, 2=rule, 3=err
- rd_data  out  CW  shadow counter selected by rd_ch/rd_sel
- snap_done  out  1  pulses when shadow set is updated

## Operation
- Beat: channel c has a beat when mon_valid[c] & mon_ready[c]. A beat is never backpressured or altered, because the block is observe-only.
- Flit counter: +1 per beat.
- Pkt counter: +1 per beat with eop=1. A beat with sop=1 and eop=1 counts as 1 packet.
- Rule counter, for RULE_MASK channels only: +N per beat, where N is the number of nonzero RW-bit slots in mon_data (0..DW/RW).
  - Slot count is computed in a pipelined popcount: stage 1 registers the per-slot nonzero flags, stage 2 sums and accumulates.
- All counters saturate at 2^CW-1 and never wrap.
- The rule add is clamped to all-ones: if counter + N would exceed 2^CW-1, the counter becomes 2^CW-1.
- Shadow set holds NCH x 4 counters. snap_req copies every live counter into it in one cycle.
  - After the copy, any rule add still in the pipeline lands in the live counter only.
- clr_req zeroes all live counters and flushes the rule pipeline. Beats in the clr_req cycle are not counted.
- snap_req and clr_req in the same cycle: the shadow set captures the pre-clear values, then the live counters are zeroed.
- Reset: all live and shadow counters, the pipeline, and the protocol state go to 0. rd_data=0, snap_done=0.

## Timing
- Flit and pkt counters: visible in the live set 1 cycle after the beat.
- Rule counter: visible 2 cycles after the beat.
- snap_done: asserted the cycle after snap_req, for 1 cycle.
- Shadow values become readable on rd_data the cycle after snap_done.
- rd_data is registered: it reflects rd_ch/rd_sel from the previous cycle.
- rd_ch >= NCH returns 0.
- snap_req repeated back-to-back: each pulse takes a fresh copy.
- Reset mid-packet: the protocol state returns to idle, and no error is counted for the truncated packet.

## Configuration
- STATS_PROTO_CHK_EN defined:
  - Each channel tracks an in-packet bit: set on a sop beat without eop, cleared on an eop beat.
  - Err counter +1 per beat with sop=1 while in-packet, and +1 per beat with sop=0 while not in-packet.
  - Only one increment per beat, even if both conditions hold.
  - Visible 1 cycle after the beat; saturates like the other counters.
- STATS_PROTO_CHK_EN undefined: no tracking logic is built, and rd_sel=3 always returns 0.

## Test plan
- Reset, then read every rd_ch/rd_sel: rd_data=0 and snap_done=0 throughout.
- Channel 0: send 3 packets of 4, 1 and 2 beats with valid/ready held high, then snap_req. Required: flit=7, pkt=3. Other channels read 0.
- RULE_MASK=4'b0010, channel 1, DW=512/RW=16: one beat with 5 nonzero slots, one beat with all 32 nonzero, one all-zero beat, then snap. Required: rule=37. Channel 0 fed the same data reads rule=0.
- CW=8: drive 300 beats on channel 2 with mon_ready toggling every cycle (150 handshakes). Required: flit=150. Then drive 200 more handshakes. Required: flit=255, pkt saturates at 255, no wrap.
- Stream beats continuously, assert snap_req and clr_req in the same cycle with 10 beats already counted. Required: shadow flit=10. The next snap reads only beats after the clr cycle.
- With STATS_PROTO_CHK_EN: sop, sop, eop on channel 3, then a sop=0 beat outside a packet. Required: err=2. Without the macro, err reads 0.
